// File: rtl/rx_descrambled_word.sv
// Receive deserializer: DPSK decode, start/stop frame alignment with lock
// hysteresis, and self-synchronous descrambling of the 10-bit payload.
module rx_descrambled_word #(
   parameter bit          DPSK        = 1'b1,
   parameter logic [22:0] SEED        = 23'd1,
   parameter bit          START_BIT   = 1'b1,
   parameter bit          STOP_BIT    = 1'b0,
   parameter int          LOCK_FRAMES = 3,
   parameter int          MISS_LIMIT  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ser_in,
   output logic [11:0] word_out,
   output logic        word_valid,
   output logic        frame_err,
   output logic        locked
);

   typedef enum logic {HUNT, FRAME} state_t;

   localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
   localparam logic [3:0] MISS_N = 4'(MISS_LIMIT);

   state_t      state, state_nxt;
   logic [3:0]  bc, bc_nxt;
   logic [3:0]  good_cnt, good_nxt;
   logic [3:0]  bad_cnt, bad_nxt;
   logic        lock_int, lock_nxt;
   logic        prev;
   logic [22:0] s;
   logic [10:0] shreg;
   logic        d, payload, bit_val, frame_done, frame_ok, emit;
   logic [11:0] frame_word;
   logic [11:0] word_p1;
   logic        emit_p1, err_p1;

   function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
      return (v >= lim) ? v : v + 4'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HUNT;
         bc    <= 4'd0;
      end else begin
         state <= state_nxt;
         bc    <= bc_nxt;
      end
   end

   // shreg[10] holds the start bit once bc reaches 11; the stop bit is d itself
   always_comb begin
      d          = DPSK ? (ser_in ^ prev) : ser_in;
      payload    = (state == FRAME) && (bc >= 4'd1) && (bc <= 4'd10);
      bit_val    = payload ? (d ^ s[3] ^ s[22]) : d;
      frame_done = (state == FRAME) && (bc == 4'd11);
      frame_word = {shreg, d};
      frame_ok   = (shreg[10] == START_BIT) && (d == STOP_BIT);
      emit       = frame_done && lock_int;
   end

   always_comb begin
      state_nxt = state;
      bc_nxt    = bc;
      good_nxt  = good_cnt;
      bad_nxt   = bad_cnt;
      lock_nxt  = lock_int;
      if (state == HUNT) begin
         if (d == START_BIT) begin
            state_nxt = FRAME;
            bc_nxt    = 4'd1;
         end
      end else if (!frame_done) begin
         bc_nxt = bc + 4'd1;
      end else begin
         bc_nxt = 4'd0;
         if (!lock_int) begin
            if (frame_ok) begin
               good_nxt = sat_inc(good_cnt, LOCK_N);
               if (good_nxt >= LOCK_N) lock_nxt = 1'b1;
            end else begin
               good_nxt  = 4'd0;
               state_nxt = HUNT;
            end
         end else begin
            bad_nxt = frame_ok ? 4'd0 : sat_inc(bad_cnt, MISS_N);
            if (bad_nxt >= MISS_N) begin
               lock_nxt  = 1'b0;
               good_nxt  = 4'd0;
               bad_nxt   = 4'd0;
               state_nxt = HUNT;
            end
         end
      end
   end

   // Stage p1: frame decision registered alongside the completed word
   always_ff @(posedge clk) begin
      if (rst) begin
         good_cnt <= 4'd0;
         bad_cnt  <= 4'd0;
         lock_int <= 1'b0;
         prev     <= 1'b0;
         s        <= SEED;
         emit_p1  <= 1'b0;
         err_p1   <= 1'b0;
      end else begin
         good_cnt <= good_nxt;
         bad_cnt  <= bad_nxt;
         lock_int <= lock_nxt;
         prev     <= ser_in;
         if (payload) s <= {s[21:0], d};
         emit_p1  <= emit;
         err_p1   <= emit && !frame_ok;
      end
   end

   always_ff @(posedge clk) begin
      shreg   <= {shreg[9:0], bit_val};
      word_p1 <= frame_word;
   end

   // Stage p2: visible outputs, one cycle after the stop bit
   always_ff @(posedge clk) begin
      if (rst) begin
         word_out   <= 12'd0;
         word_valid <= 1'b0;
         frame_err  <= 1'b0;
         locked     <= 1'b0;
      end else begin
         word_valid <= emit_p1;
         frame_err  <= err_p1;
         locked     <= lock_int;
         if (emit_p1) word_out <= word_p1;
      end
   end

endmodule

// File: tb/tb_rx_descrambled_word.sv
// Bench for rx_descrambled_word: a DPSK/seed-1 instance and an ASK/seed-all-ones
// instance fed by the same scrambling transmitter, checked against a frame model.
module tb_rx_descrambled_word;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, ser0, ser1;
   logic [11:0] word0, word1;
   logic        valid0, valid1, err0, err1, lock0, lock1;

   rx_descrambled_word dut0 (
      .clk(clk), .rst(rst), .ser_in(ser0),
      .word_out(word0), .word_valid(valid0), .frame_err(err0), .locked(lock0)
   );

   rx_descrambled_word #(.DPSK(1'b0), .SEED(23'h7FFFFF)) dut1 (
      .clk(clk), .rst(rst), .ser_in(ser1),
      .word_out(word1), .word_valid(valid1), .frame_err(err1), .locked(lock1)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Receiver model: frames are collected as whole words, payload history is a ring of received bits.
   bit          m_prev [2];
   bit          m_hist [2][32];
   int          m_wp   [2];
   int          m_pos  [2];
   logic [11:0] m_acc  [2];
   int          m_good [2];
   int          m_bad  [2];
   bit          m_lock [2];
   bit          p_valid[2];
   bit          p_err  [2];
   logic [11:0] p_word [2];
   bit          e_valid[2];
   bit          e_err  [2];
   bit          e_lock [2];
   logic [11:0] e_word [2];
   bit          model_live = 1'b0;

   function automatic logic [22:0] seed_of(input int i);
      return (i == 0) ? 23'd1 : 23'h7FFFFF;
   endfunction

   function automatic bit age(input int i, input int k);
      return m_hist[i][(m_wp[i] + 31 - k) % 32];
   endfunction

   task automatic model_step(input int i, input bit r, input bit line);
      bit          d, b, ok;
      logic [22:0] sd;
      if (r) begin
         sd = seed_of(i);
         m_prev[i] = 1'b0;
         m_wp[i]   = 0;
         for (int k = 0; k < 23; k++) m_hist[i][31 - k] = sd[k];
         m_pos[i]  = -1;
         m_good[i] = 0;
         m_bad[i]  = 0;
         m_lock[i] = 1'b0;
         p_valid[i] = 1'b0; p_err[i] = 1'b0;
         e_valid[i] = 1'b0; e_err[i] = 1'b0; e_lock[i] = 1'b0; e_word[i] = 12'd0;
         return;
      end
      e_valid[i] = p_valid[i];
      e_err[i]   = p_err[i];
      if (p_valid[i]) e_word[i] = p_word[i];
      e_lock[i]  = m_lock[i];
      p_valid[i] = 1'b0;
      p_err[i]   = 1'b0;
      d = (i == 0) ? (line ^ m_prev[i]) : line;
      m_prev[i] = line;
      if (m_pos[i] < 0) begin
         if (d) begin
            m_acc[i] = 12'd1;
            m_pos[i] = 1;
         end
         return;
      end
      b = d;
      if (m_pos[i] >= 1 && m_pos[i] <= 10) begin
         b = d ^ age(i, 3) ^ age(i, 22);
         m_hist[i][m_wp[i]] = d;
         m_wp[i] = (m_wp[i] + 1) % 32;
      end
      m_acc[i] = {m_acc[i][10:0], b};
      m_pos[i]++;
      if (m_pos[i] == 12) begin
         ok = (m_acc[i][11] == 1'b1) && (m_acc[i][0] == 1'b0);
         m_pos[i] = 0;
         if (m_lock[i]) begin
            p_valid[i] = 1'b1;
            p_word[i]  = m_acc[i];
            p_err[i]   = !ok;
            m_bad[i]   = ok ? 0 : m_bad[i] + 1;
            if (m_bad[i] >= 4) begin
               m_lock[i] = 1'b0; m_good[i] = 0; m_bad[i] = 0; m_pos[i] = -1;
            end
         end else if (ok) begin
            m_good[i]++;
            if (m_good[i] >= 3) m_lock[i] = 1'b1;
         end else begin
            m_good[i] = 0;
            m_pos[i]  = -1;
         end
      end
   endtask

   always @(posedge clk) begin
      model_step(0, rst, ser0);
      model_step(1, rst, ser1);
      if (rst) model_live = 1'b1;
   end

   always @(negedge clk) begin
      if (model_live) begin
         check("word0",  word0,        e_word[0]);
         check("valid0", 12'(valid0),  12'(e_valid[0]));
         check("err0",   12'(err0),    12'(e_err[0]));
         check("lock0",  12'(lock0),   12'(e_lock[0]));
         check("word1",  word1,        e_word[1]);
         check("valid1", 12'(valid1),  12'(e_valid[1]));
         check("err1",   12'(err1),    12'(e_err[1]));
         check("lock1",  12'(lock1),   12'(e_lock[1]));
      end
   end

   // Transmitter: scrambles payload bits, ser0 is the DPSK line, ser1 the ASK line.
   logic [22:0] tx_s;
   bit          tx_prev;

   task automatic send_word(input logic [11:0] w, input bit bad_stop, input int rst_k, input int chk_k,
                            input string tag, input bit x_lock, input bit x_valid, input bit x_err,
                            input bit wchk, input logic [11:0] x_word);
      for (int k = 11; k >= 0; k--) begin
         bit b, sc;
         b = w[k];
         if (k == 0 && bad_stop) b = ~b;
         if (k >= 1 && k <= 10) begin
            sc   = b ^ tx_s[3] ^ tx_s[22];
            tx_s = {tx_s[21:0], sc};
            b    = sc;
         end
         tx_prev = tx_prev ^ b;
         ser0 = tx_prev;
         ser1 = b;
         rst  = (k == rst_k);
         @(posedge clk);
         #1;
         if (k == chk_k) begin
            check({tag, "_lock0"},  12'(lock0),  12'(x_lock));
            check({tag, "_valid0"}, 12'(valid0), 12'(x_valid));
            check({tag, "_err0"},   12'(err0),   12'(x_err));
            check({tag, "_lock1"},  12'(lock1),  12'(x_lock));
            check({tag, "_valid1"}, 12'(valid1), 12'(x_valid));
            check({tag, "_err1"},   12'(err1),   12'(x_err));
            if (wchk) begin
               check({tag, "_word0"}, word0, x_word);
               check({tag, "_word1"}, word1, x_word);
            end
         end
      end
      rst = 1'b0;
   endtask

   task automatic plain(input logic [11:0] w, input bit bad_stop);
      send_word(w, bad_stop, -1, -1, "", 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
   endtask

   localparam logic [11:0] WA = 12'h8AA;
   localparam logic [11:0] WB = 12'h8AB;
   localparam logic [11:0] WF = 12'hFFE;

   initial begin
      logic [11:0] w;
      rst = 1'b1; ser0 = 1'b0; ser1 = 1'b0;
      tx_s = 23'd1; tx_prev = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // aligned lock and hold
      plain(WA, 1'b0);
      plain(WA, 1'b0);
      send_word(WA, 1'b0, -1, 11, "f2",  1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
      send_word(WA, 1'b0, -1, 11, "f3",  1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
      send_word(WA, 1'b0, -1, 11, "f4",  1'b1, 1'b1, 1'b0, 1'b1, WA);
      // three bad stops, a good frame, then four bad stops
      send_word(WA, 1'b1, -1, 11, "f5",  1'b1, 1'b1, 1'b0, 1'b1, WA);
      send_word(WA, 1'b1, -1, 11, "f6",  1'b1, 1'b1, 1'b1, 1'b1, WB);
      send_word(WA, 1'b1, -1, 11, "f7",  1'b1, 1'b1, 1'b1, 1'b1, WB);
      send_word(WA, 1'b0, -1, 11, "f8",  1'b1, 1'b1, 1'b1, 1'b1, WB);
      send_word(WA, 1'b1, -1, 11, "f9",  1'b1, 1'b1, 1'b0, 1'b1, WA);
      send_word(WA, 1'b1, -1, 11, "f10", 1'b1, 1'b1, 1'b1, 1'b1, WB);
      send_word(WA, 1'b1, -1, 11, "f11", 1'b1, 1'b1, 1'b1, 1'b1, WB);
      send_word(WA, 1'b1, -1, 11, "f12", 1'b1, 1'b1, 1'b1, 1'b1, WB);
      send_word(WA, 1'b0, -1, 11, "f13", 1'b0, 1'b1, 1'b1, 1'b1, WB);
      // reacquire from a start bit that lands on the frame boundary
      send_word(WA, 1'b0, -1, 11, "f14", 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
      send_word(WA, 1'b0, -1, 11, "f15", 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
      send_word(WA, 1'b0, -1, 11, "f16", 1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
      // reset mid-frame while locked
      send_word(WA, 1'b0, 5, 5, "rstmid", 1'b0, 1'b0, 1'b0, 1'b1, 12'd0);
      for (int f = 0; f < 24; f++) plain((f % 2) ? WF : WA, 1'b0);

      // receiver restarted at an arbitrary bit phase
      send_word(WA, 1'b0, 7, -1, "", 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
      for (int f = 0; f < 30; f++) plain((f % 2) ? WA : WF, 1'b0);

      // random payloads with occasional bad stop bits
      for (int f = 0; f < 60; f++) begin
         w = {1'b1, 10'($urandom), 1'b0};
         plain(w, $urandom_range(0, 7) == 0);
      end
      plain(WA, 1'b0);
      plain(WA, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
